// File: rtl/muldiv_sequencer.sv
// Multi-cycle MIPS multiply/divide unit owning HI/LO.
// One 33-bit add/subtract step per cycle, 32 iterations, then a finish cycle
// that applies sign correction and writes HI/LO.
//
// state  | meaning
// IDLE   | accepting start; MTHI/MTLO execute here in one cycle
// RUN    | 32 shift-add (multiply) or restoring (divide) steps
// FINISH | sign-correct working result, write HI/LO, pulse done
module muldiv_sequencer (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [5:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [5:0] OP_MULT  = 6'b011000;
  localparam logic [5:0] OP_MULTU = 6'b011001;
  localparam logic [5:0] OP_DIV   = 6'b011010;
  localparam logic [5:0] OP_DIVU  = 6'b011011;
  localparam logic [5:0] OP_MTHI  = 6'b010001;
  localparam logic [5:0] OP_MTLO  = 6'b010011;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FINISH} state_t;

  state_t      state_q, state_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic [4:0]  count_q, count_d;
  logic        is_div_q, is_div_d;
  logic        neg_q, neg_d;           // negate product / quotient
  logic        neg_rem_q, neg_rem_d;   // remainder takes sign of dividend
  logic [31:0] opnd_q, opnd_d;         // multiplicand or divisor magnitude
  logic [63:0] work_q, work_d;         // {acc, multiplier} or {rem, quot}

  logic        md_op;
  logic        signed_op;
  logic [31:0] abs_a;
  logic [31:0] abs_b;
  logic [32:0] mul_sum;
  logic [63:0] mul_next;
  logic [32:0] div_diff;
  logic [63:0] div_next;

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

  // Next-state, datapath step and output computation.
  always_comb begin
    state_d   = state_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    hi_d      = hi_q;
    lo_d      = lo_q;
    count_d   = count_q;
    is_div_d  = is_div_q;
    neg_d     = neg_q;
    neg_rem_d = neg_rem_q;
    opnd_d    = opnd_q;
    work_d    = work_q;

    md_op     = (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
    signed_op = ~op[0];
    abs_a     = (signed_op && a[31]) ? -a : a;
    abs_b     = (signed_op && b[31]) ? -b : b;

    mul_sum   = {1'b0, work_q[63:32]} + {1'b0, opnd_q};
    mul_next  = work_q[0] ? {mul_sum, work_q[31:1]} : {1'b0, work_q[63:1]};

    // Rem is always below the divisor, so the shifted rem fits in 33 bits.
    div_diff  = work_q[63:31] - {1'b0, opnd_q};
    div_next  = div_diff[32] ? {work_q[62:0], 1'b0}
                             : {div_diff[31:0], work_q[30:0], 1'b1};

    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (md_op) begin
            state_d   = S_RUN;
            busy_d    = 1'b1;
            count_d   = 5'd0;
            is_div_d  = op[1];
            opnd_d    = op[1] ? abs_b : abs_a;
            work_d    = {32'd0, (op[1] ? abs_a : abs_b)};
            // Divide by zero yields an all-ones quotient; keep it unnegated.
            neg_d     = signed_op && (a[31] ^ b[31]) && !(op[1] && (b == 32'd0));
            neg_rem_d = signed_op && a[31];
          end else if (op == OP_MTHI) begin
            hi_d = a;
          end else if (op == OP_MTLO) begin
            lo_d = a;
          end
        end
      end
      S_RUN: begin
        work_d  = is_div_q ? div_next : mul_next;
        count_d = count_q + 5'd1;
        if (count_q == 5'd31) begin
          state_d = S_FINISH;
        end
      end
      S_FINISH: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
        if (is_div_q) begin
          lo_d = neg_q ? -work_q[31:0] : work_q[31:0];
          hi_d = neg_rem_q ? -work_q[63:32] : work_q[63:32];
        end else begin
          {hi_d, lo_d} = neg_q ? -work_q : work_q;
        end
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
      count_q   <= 5'd0;
      is_div_q  <= 1'b0;
      neg_q     <= 1'b0;
      neg_rem_q <= 1'b0;
      opnd_q    <= 32'd0;
      work_q    <= 64'd0;
    end else begin
      state_q   <= state_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      count_q   <= count_d;
      is_div_q  <= is_div_d;
      neg_q     <= neg_d;
      neg_rem_q <= neg_rem_d;
      opnd_q    <= opnd_d;
      work_q    <= work_d;
    end
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer: arithmetic reference model plus
// directed scenarios and randomized traffic.
module tb_muldiv_sequencer;

  localparam logic [5:0] OP_MULT  = 6'b011000;
  localparam logic [5:0] OP_MULTU = 6'b011001;
  localparam logic [5:0] OP_DIV   = 6'b011010;
  localparam logic [5:0] OP_DIVU  = 6'b011011;
  localparam logic [5:0] OP_MTHI  = 6'b010001;
  localparam logic [5:0] OP_MTLO  = 6'b010011;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [5:0]  op = 6'd0;
  logic [31:0] a = 32'd0;
  logic [31:0] b = 32'd0;
  logic        busy, done;
  logic [31:0] hi, lo;

  int total = 0;
  int bad = 0;
  bit cmp_en = 1'b0;
  bit seen_dead = 1'b0;
  bit watch_dead = 1'b0;

  muldiv_sequencer dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  always #5 clk = ~clk;

  // Reference result {hi, lo} straight from the arithmetic definition.
  function automatic logic [63:0] ref_op(input logic [5:0] o, input logic [31:0] x, input logic [31:0] y);
    longint sx, sy, q, r;
    logic [63:0] res;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    res = 64'd0;
    case (o)
      OP_MULTU: res = {32'd0, x} * {32'd0, y};
      OP_MULT:  res = sx * sy;
      OP_DIVU:  res = (y == 32'd0) ? {x, 32'hFFFFFFFF} : {x % y, x / y};
      OP_DIV: begin
        if (y == 32'd0) begin
          res = {x, 32'hFFFFFFFF};
        end else begin
          q = sx / sy;
          r = sx % sy;
          res = {r[31:0], q[31:0]};
        end
      end
      default: res = 64'd0;
    endcase
    return res;
  endfunction

  function automatic bit is_md(input logic [5:0] o);
    return (o == OP_MULT) || (o == OP_MULTU) || (o == OP_DIV) || (o == OP_DIVU);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: an accepted mul/div finishes 33 edges later.
  logic [31:0] m_hi = 32'd0, m_lo = 32'd0;
  logic        m_busy = 1'b0, m_done = 1'b0;
  logic [63:0] m_pend = 64'd0;
  int          m_left = 0;

  always @(posedge clk) begin
    if (reset) begin
      m_hi <= 32'd0; m_lo <= 32'd0; m_busy <= 1'b0; m_done <= 1'b0; m_left <= 0;
    end else if (m_left > 0) begin
      if (m_left == 1) begin
        m_hi <= m_pend[63:32]; m_lo <= m_pend[31:0]; m_done <= 1'b1; m_busy <= 1'b0;
      end
      m_left <= m_left - 1;
    end else begin
      m_done <= 1'b0;
      if (start) begin
        if (is_md(op)) begin
          m_pend <= ref_op(op, a, b);
          m_left <= 33;
          m_busy <= 1'b1;
        end else if (op == OP_MTHI) begin
          m_hi <= a;
        end else if (op == OP_MTLO) begin
          m_lo <= a;
        end
      end
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("busy", {63'd0, busy}, {63'd0, m_busy});
      chk("done", {63'd0, done}, {63'd0, m_done});
      chk("hi", {32'd0, hi}, {32'd0, m_hi});
      chk("lo", {32'd0, lo}, {32'd0, m_lo});
    end
    if (watch_dead && lo == 32'h0000DEAD) seen_dead = 1'b1;
  end

  // Issue a mul/div, check the busy length, done timing and the literal result.
  task automatic issue_wait(input logic [5:0] o, input logic [31:0] x, input logic [31:0] y,
                            input logic [31:0] exp_hi, input logic [31:0] exp_lo, input string name);
    int n;
    bit got;
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clk); #1;
    start = 1'b0; op = 6'd0;
    n = 0;
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (done) got = 1'b1;
      else if (busy) n++;
    end
    chk({name, "_timeout"}, {63'd0, got}, 64'd1);
    chk({name, "_busy_cycles"}, 64'(n), 64'd33);
    chk({name, "_done_busy"}, {63'd0, busy}, 64'd0);
    chk({name, "_hi"}, {32'd0, hi}, {32'd0, exp_hi});
    chk({name, "_lo"}, {32'd0, lo}, {32'd0, exp_lo});
    @(posedge clk); #1;
  endtask

  function automatic logic [31:0] pick_val();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFFFFFF;
      3: return 32'h80000000;
      4: return 32'h7FFFFFFF;
      5: return $urandom_range(0, 20);
      default: return $urandom;
    endcase
  endfunction

  function automatic logic [5:0] pick_op();
    case ($urandom_range(0, 7))
      0: return OP_MULT;
      1: return OP_MULTU;
      2: return OP_DIV;
      3: return OP_DIVU;
      4: return OP_MTHI;
      5: return OP_MTLO;
      6: return 6'($urandom);
      default: return OP_DIV;
    endcase
  endfunction

  initial begin
    // Pin the reference model against hand-computed values.
    chk("ref_multu_max", ref_op(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF), 64'hFFFFFFFE_00000001);
    chk("ref_mult_neg", ref_op(OP_MULT, 32'hFFFFFFFD, 32'd5), 64'hFFFFFFFF_FFFFFFF1);
    chk("ref_div_neg", ref_op(OP_DIV, 32'hFFFFFFF9, 32'd2), 64'hFFFFFFFF_FFFFFFFD);
    chk("ref_div_ovf", ref_op(OP_DIV, 32'h80000000, 32'hFFFFFFFF), 64'h00000000_80000000);
    chk("ref_divu_zero", ref_op(OP_DIVU, 32'd100, 32'd0), 64'h00000064_FFFFFFFF);
    chk("ref_div_zero_neg", ref_op(OP_DIV, 32'hFFFFFFF0, 32'd0), 64'hFFFFFFF0_FFFFFFFF);

    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    cmp_en = 1'b1;
    @(negedge clk);
    chk("reset_busy", {63'd0, busy}, 64'd0);
    chk("reset_done", {63'd0, done}, 64'd0);
    chk("reset_hi", {32'd0, hi}, 64'd0);
    chk("reset_lo", {32'd0, lo}, 64'd0);
    @(posedge clk); #1;

    issue_wait(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, "multu_max");
    issue_wait(OP_MULT, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFF1, "mult_neg");
    issue_wait(OP_DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, "div_neg");
    issue_wait(OP_DIVU, 32'd100, 32'd0, 32'h00000064, 32'hFFFFFFFF, "divu_zero");
    issue_wait(OP_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, "div_ovf");

    // MTHI then MTLO on consecutive cycles.
    start = 1'b1; op = OP_MTHI; a = 32'h12345678; b = 32'd0;
    @(posedge clk); #1;
    op = OP_MTLO; a = 32'h9ABCDEF0;
    chk("mthi_hi", {32'd0, hi}, 64'h12345678);
    chk("mthi_lo_kept", {32'd0, lo}, 64'h80000000);
    chk("mthi_busy", {63'd0, busy}, 64'd0);
    @(posedge clk); #1;
    start = 1'b0; op = 6'd0;
    chk("mtlo_lo", {32'd0, lo}, 64'h9ABCDEF0);
    chk("mtlo_done", {63'd0, done}, 64'd0);

    // Requests while busy are ignored.
    watch_dead = 1'b1;
    start = 1'b1; op = OP_MULTU; a = 32'd7; b = 32'd9;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    start = 1'b1; op = OP_MTLO; a = 32'h0000DEAD;
    @(posedge clk); #1;
    op = OP_DIVU; a = 32'd50; b = 32'd7;
    @(posedge clk); #1;
    start = 1'b0; op = 6'd0;
    begin
      bit got;
      got = 1'b0;
      for (int i = 0; i < 40 && !got; i++) begin
        @(negedge clk);
        if (done) got = 1'b1;
      end
      chk("busy_ign_timeout", {63'd0, got}, 64'd1);
      chk("busy_ign_hi", {32'd0, hi}, 64'd0);
      chk("busy_ign_lo", {32'd0, lo}, 64'd63);
    end
    repeat (3) @(posedge clk);
    #1;
    watch_dead = 1'b0;
    chk("no_dead_seen", {63'd0, seen_dead}, 64'd0);
    chk("busy_ign_idle", {63'd0, busy}, 64'd0);

    // Reset mid-divide, then a full divide.
    start = 1'b1; op = OP_DIVU; a = 32'd1000; b = 32'd3;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("midrst_busy", {63'd0, busy}, 64'd0);
    chk("midrst_done", {63'd0, done}, 64'd0);
    chk("midrst_hi", {32'd0, hi}, 64'd0);
    chk("midrst_lo", {32'd0, lo}, 64'd0);
    issue_wait(OP_DIVU, 32'd1000, 32'd3, 32'd1, 32'd333, "divu_after_rst");

    // Randomized traffic checked cycle by cycle against the model.
    for (int c = 0; c < 5000; c++) begin
      reset = ($urandom_range(0, 999) == 0);
      start = ($urandom_range(0, 2) == 0);
      op = pick_op();
      a = pick_val();
      b = pick_val();
      @(posedge clk); #1;
    end
    reset = 1'b0;
    start = 1'b0;
    repeat (40) @(posedge clk);
    #1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
